// File: rtl/matrix_mul_seq.sv
// Sequencer for a 4x4 single-precision matrix product C = A x B.
// It feeds an external dot-product unit one row/column pair per cycle and collects the results into C.
module matrix_mul_seq #(
  parameter int DOT_LAT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] mat_a,
  input  logic [511:0] mat_b,
  output logic [127:0] dot_a,
  output logic [127:0] dot_b,
  output logic         dot_issue,
  input  logic [31:0]  dot_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] mat_c,
  output logic         busy
);

  // state | meaning
  // IDLE  | waiting for a job, in_ready high
  // RUN   | issuing pairs and collecting results
  // DONE  | mat_c complete, waiting for out_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [511:0]   a_q, b_q;
  logic [3:0]     idx;
  logic           issue_end;
  logic           wb_live;
  logic [3:0]     wb_idx;
  logic [1:0]     row, col;

  assign row = idx[3:2];
  assign col = idx[1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (wb_live && wb_idx == 4'd15) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
    dot_issue = (state == RUN) && !issue_end;
  end

  // idx stops at 15; issue_end marks that the last pair has gone out.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx       <= 4'd0;
      issue_end <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q       <= mat_a;
      b_q       <= mat_b;
      idx       <= 4'd0;
      issue_end <= 1'b0;
    end else if (dot_issue) begin
      if (idx == 4'd15) issue_end <= 1'b1;
      else              idx       <= idx + 4'd1;
    end
  end

  always_comb begin
    dot_a = a_q[{row, 7'b0} +: 128];
    dot_b = '0;
    for (int k = 0; k < 4; k++)
      dot_b[32*k +: 32] = b_q[128*k + 32*int'(col) +: 32];
  end

  generate
    if (DOT_LAT == 0) begin : g_comb
      assign wb_live = dot_issue;
      assign wb_idx  = idx;
    end else begin : g_pipe
      logic [DOT_LAT-1:0] live_q;
      logic [3:0]         idx_q [DOT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          live_q <= '0;
        end else begin
          live_q[0] <= dot_issue;
          for (int i = 1; i < DOT_LAT; i++) live_q[i] <= live_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        idx_q[0] <= idx;
        for (int i = 1; i < DOT_LAT; i++) idx_q[i] <= idx_q[i-1];
      end

      assign wb_live = live_q[DOT_LAT-1];
      assign wb_idx  = idx_q[DOT_LAT-1];
    end
  endgenerate

  // dot_result is only looked at when a tracked issue lands, so garbage elsewhere is harmless.
  always_ff @(posedge clk) begin
    if (rst)          mat_c <= '0;
    else if (wb_live) mat_c[{wb_idx, 5'b0} +: 32] <= dot_result;
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Bench for matrix_mul_seq: a combinational (DOT_LAT=0) and a 3-stage (DOT_LAT=3) instance,
// each fed by a bench dot-product model, with expected matrices queued at job acceptance.
module tb_matrix_mul_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [511:0] mat_a, mat_b;

  logic         in_valid0, in_ready0, dot_issue0, out_valid0, out_ready0, busy0;
  logic [127:0] dot_a0, dot_b0;
  logic [31:0]  dot_res0;
  logic [511:0] mat_c0;

  logic         in_valid3, in_ready3, dot_issue3, out_valid3, out_ready3, busy3;
  logic [127:0] dot_a3, dot_b3;
  logic [31:0]  dot_res3;
  logic [511:0] mat_c3;

  int vectors = 0;
  int miscompares = 0;
  logic [511:0] exp_q0[$];
  logic [511:0] exp_q3[$];

  matrix_mul_seq #(.DOT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .mat_a(mat_a), .mat_b(mat_b), .dot_a(dot_a0), .dot_b(dot_b0),
    .dot_issue(dot_issue0), .dot_result(dot_res0), .out_valid(out_valid0),
    .out_ready(out_ready0), .mat_c(mat_c0), .busy(busy0)
  );

  matrix_mul_seq #(.DOT_LAT(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .mat_a(mat_a), .mat_b(mat_b), .dot_a(dot_a3), .dot_b(dot_b3),
    .dot_issue(dot_issue3), .dot_result(dot_res3), .out_valid(out_valid3),
    .out_ready(out_ready3), .mat_c(mat_c3), .busy(busy3)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [10:0] e;
    logic [63:0] d;
    e = {3'b000, f[30:23]} + 11'd896;
    d = (f[30:0] == 31'd0) ? {f[31], 63'd0} : {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return (d[62:0] == 63'd0) ? {d[63], 31'd0} : {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] dotp(input logic [127:0] va, input logic [127:0] vb);
    real s;
    s = 0.0;
    for (int k = 0; k < 4; k++) s = s + f2r(va[32*k +: 32]) * f2r(vb[32*k +: 32]);
    return r2f(s);
  endfunction

  function automatic logic [511:0] matmul(input logic [511:0] a, input logic [511:0] b);
    logic [511:0] c;
    logic [127:0] colv;
    c = '0;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++) begin
        for (int k = 0; k < 4; k++) colv[32*k +: 32] = b[128*k + 32*cc +: 32];
        c[128*r + 32*cc +: 32] = dotp(a[128*r +: 128], colv);
      end
    return c;
  endfunction

  function automatic logic [511:0] identity_mat();
    logic [511:0] m;
    m = '0;
    for (int r = 0; r < 4; r++) m[128*r + 32*r +: 32] = 32'h3F800000;
    return m;
  endfunction

  function automatic logic [511:0] seq_mat();
    logic [511:0] m;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) m[128*r + 32*c +: 32] = r2f(real'(4*r + c + 1));
    return m;
  endfunction

  function automatic logic [511:0] rand_mat();
    logic [511:0] m;
    for (int i = 0; i < 16; i++) m[32*i +: 32] = r2f(real'($urandom_range(0, 7)));
    return m;
  endfunction

  // Bench dot units; garbage is driven whenever no live result is due.
  always_comb dot_res0 = dot_issue0 ? dotp(dot_a0, dot_b0) : 32'hDEADBEEF;

  logic [2:0]  pv3 = 3'b000;
  logic [31:0] pd3 [3];
  always @(posedge clk) begin
    pv3    <= {pv3[1:0], dot_issue3};
    pd3[2] <= pd3[1];
    pd3[1] <= pd3[0];
    pd3[0] <= dotp(dot_a3, dot_b3);
  end
  assign dot_res3 = pv3[2] ? pd3[2] : 32'hBAD0BAD0;

  task automatic start_job(input bit sel, input logic [511:0] a, input logic [511:0] b);
    @(posedge clk); #1;
    mat_a = a;
    mat_b = b;
    if (sel) begin in_valid3 = 1'b1; exp_q3.push_back(matmul(a, b)); end
    else     begin in_valid0 = 1'b1; exp_q0.push_back(matmul(a, b)); end
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_valid3 = 1'b0;
    mat_a = ~a;
    mat_b = ~b;
  endtask

  task automatic measure(input bit sel, output int first, output int issues,
                         output logic [127:0] a5, output logic [127:0] b5);
    first = -1; issues = 0; a5 = '0; b5 = '0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (sel ? dot_issue3 : dot_issue0) issues++;
      if (n == 5) begin
        a5 = sel ? dot_a3 : dot_a0;
        b5 = sel ? dot_b3 : dot_b0;
      end
      if (sel ? out_valid3 : out_valid0) begin first = n; break; end
    end
  endtask

  task automatic release_out(input bit sel);
    @(posedge clk); #1;
    if (sel) out_ready3 = 1'b1; else out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    out_ready3 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid0 = 0; in_valid3 = 0; out_ready0 = 0; out_ready3 = 0;
    mat_a = '0; mat_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (in_ready0 !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b expected 1", in_ready0); end
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b expected 0", out_valid0); end
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b expected 0", busy0); end
    vectors++; if (dot_issue0 !== 1'b0) begin miscompares++; $display("FAIL reset_dot_issue got %b expected 0", dot_issue0); end
    vectors++; if (mat_c0 !== 512'd0) begin miscompares++; $display("FAIL reset_mat_c got %h expected 0", mat_c0); end
    vectors++; if (in_ready3 !== 1'b1 || busy3 !== 1'b0) begin miscompares++; $display("FAIL reset_lat3 got in_ready %b busy %b expected 1 0", in_ready3, busy3); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    logic [511:0] a, b, exp_c;
    logic [127:0] a5, b5, exp_b5;
    int first, issues;
    a = identity_mat(); b = seq_mat();
    for (int k = 0; k < 4; k++) exp_b5[32*k +: 32] = r2f(real'(4*k + 2));
    start_job(1'b0, a, b);
    measure(1'b0, first, issues, a5, b5);
    exp_c = exp_q0.pop_front();
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL ident_valid_cycle got %0d expected 16", first); end
    vectors++; if (issues !== 16) begin miscompares++; $display("FAIL ident_issue_count got %0d expected 16", issues); end
    vectors++; if (a5 !== {32'h0, 32'h0, 32'h3F800000, 32'h0}) begin miscompares++; $display("FAIL ident_dot_a5 got %h expected row 1 of identity", a5); end
    vectors++; if (b5 !== exp_b5) begin miscompares++; $display("FAIL ident_dot_b5 got %h expected %h", b5, exp_b5); end
    vectors++; if (mat_c0 !== b) begin miscompares++; $display("FAIL ident_mat_c got %h expected %h", mat_c0, b); end
    vectors++; if (mat_c0 !== exp_c) begin miscompares++; $display("FAIL ident_scoreboard got %h expected %h", mat_c0, exp_c); end
    release_out(1'b0);
  endtask

  task automatic test_fill();
    logic [511:0] exp_c;
    logic [127:0] a5, b5;
    int first, issues;
    start_job(1'b0, {16{32'h40000000}}, {16{32'h3F800000}});
    measure(1'b0, first, issues, a5, b5);
    exp_c = exp_q0.pop_front();
    vectors++; if (a5 !== {4{32'h40000000}}) begin miscompares++; $display("FAIL fill_dot_a5 got %h expected all 40000000", a5); end
    vectors++; if (b5 !== {4{32'h3F800000}}) begin miscompares++; $display("FAIL fill_dot_b5 got %h expected all 3F800000", b5); end
    vectors++; if (mat_c0 !== {16{32'h41000000}}) begin miscompares++; $display("FAIL fill_mat_c got %h expected all 41000000", mat_c0); end
    vectors++; if (mat_c0 !== exp_c) begin miscompares++; $display("FAIL fill_scoreboard got %h expected %h", mat_c0, exp_c); end
    release_out(1'b0);
  endtask

  task automatic test_hold();
    logic [511:0] a2, b2, held, exp_c;
    logic [127:0] a5, b5;
    int first, issues;
    start_job(1'b0, rand_mat(), rand_mat());
    measure(1'b0, first, issues, a5, b5);
    held = exp_q0.pop_front();
    vectors++; if (first !== 16) begin miscompares++; $display("FAIL hold_valid_cycle got %0d expected 16", first); end
    a2 = rand_mat(); b2 = rand_mat();
    mat_a = a2; mat_b = b2; in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (out_valid0 !== 1'b1) begin miscompares++; $display("FAIL hold_out_valid cycle %0d got %b expected 1", i, out_valid0); end
      vectors++; if (in_ready0 !== 1'b0) begin miscompares++; $display("FAIL hold_in_ready cycle %0d got %b expected 0", i, in_ready0); end
      vectors++; if (mat_c0 !== held) begin miscompares++; $display("FAIL hold_mat_c cycle %0d got %h expected %h", i, mat_c0, held); end
    end
    @(posedge clk); #1 out_ready0 = 1'b1;
    @(posedge clk); #1 out_ready0 = 1'b0;
    @(negedge clk);
    vectors++; if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin miscompares++; $display("FAIL hold_idle got in_ready %b out_valid %b expected 1 0", in_ready0, out_valid0); end
    exp_q0.push_back(matmul(a2, b2));
    @(posedge clk); #1;
    in_valid0 = 1'b0; mat_a = '0; mat_b = '0;
    measure(1'b0, first, issues, a5, b5);
    exp_c = exp_q0.pop_front();
    vectors++; if (first !== 16 || issues !== 16) begin miscompares++; $display("FAIL hold_next_job got valid %0d issues %0d expected 16 16", first, issues); end
    vectors++; if (mat_c0 !== exp_c) begin miscompares++; $display("FAIL hold_next_mat_c got %h expected %h", mat_c0, exp_c); end
    release_out(1'b0);
  endtask

  task automatic test_reset_mid();
    logic [511:0] exp_c, discard;
    logic [127:0] a5, b5;
    int first, issues;
    start_job(1'b0, seq_mat(), seq_mat());
    repeat (8) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    discard = exp_q0.pop_back();
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0 || in_ready0 !== 1'b1) begin miscompares++; $display("FAIL rstmid_idle got busy %b in_ready %b expected 0 1", busy0, in_ready0); end
    vectors++; if (out_valid0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %b expected 0", out_valid0); end
    vectors++; if (dot_issue0 !== 1'b0) begin miscompares++; $display("FAIL rstmid_dot_issue got %b expected 0", dot_issue0); end
    vectors++; if (mat_c0 !== 512'd0) begin miscompares++; $display("FAIL rstmid_mat_c got %h expected 0 (job was %h)", mat_c0, discard[31:0]); end
    start_job(1'b0, rand_mat(), rand_mat());
    measure(1'b0, first, issues, a5, b5);
    exp_c = exp_q0.pop_front();
    vectors++; if (first !== 16 || issues !== 16) begin miscompares++; $display("FAIL rstmid_new_job got valid %0d issues %0d expected 16 16", first, issues); end
    vectors++; if (mat_c0 !== exp_c) begin miscompares++; $display("FAIL rstmid_new_mat_c got %h expected %h", mat_c0, exp_c); end
    release_out(1'b0);
  endtask

  task automatic test_lat3();
    logic [511:0] b, exp_c;
    logic [127:0] a5, b5;
    int first, issues;
    b = seq_mat();
    start_job(1'b1, identity_mat(), b);
    measure(1'b1, first, issues, a5, b5);
    exp_c = exp_q3.pop_front();
    vectors++; if (first !== 19) begin miscompares++; $display("FAIL lat3_valid_cycle got %0d expected 19", first); end
    vectors++; if (issues !== 16) begin miscompares++; $display("FAIL lat3_issue_count got %0d expected 16", issues); end
    vectors++; if (mat_c3 !== b) begin miscompares++; $display("FAIL lat3_mat_c got %h expected %h", mat_c3, b); end
    vectors++; if (mat_c3 !== exp_c) begin miscompares++; $display("FAIL lat3_scoreboard got %h expected %h", mat_c3, exp_c); end
    release_out(1'b1);
    start_job(1'b1, rand_mat(), rand_mat());
    measure(1'b1, first, issues, a5, b5);
    exp_c = exp_q3.pop_front();
    vectors++; if (mat_c3 !== exp_c) begin miscompares++; $display("FAIL lat3_rand_mat_c got %h expected %h", mat_c3, exp_c); end
    release_out(1'b1);
  endtask

  task automatic test_back_to_back();
    logic [511:0] exp_c;
    int accepts, dones, last_done;
    bit acc;
    accepts = 0; dones = 0; last_done = -1;
    @(posedge clk); #1;
    mat_a = rand_mat(); mat_b = rand_mat();
    in_valid0 = 1'b1; out_ready0 = 1'b1;
    for (int cyc = 0; cyc < 120 && dones < 3; cyc++) begin
      @(negedge clk);
      acc = in_ready0 && in_valid0;
      if (out_valid0) begin
        exp_c = exp_q0.pop_front();
        vectors++; if (mat_c0 !== exp_c) begin miscompares++; $display("FAIL b2b_mat_c job %0d got %h expected %h", dones, mat_c0, exp_c); end
        if (last_done >= 0) begin
          vectors++; if (cyc - last_done !== 18) begin miscompares++; $display("FAIL b2b_period got %0d expected 18", cyc - last_done); end
        end
        last_done = cyc;
        dones++;
      end
      @(posedge clk); #1;
      if (acc) begin
        exp_q0.push_back(matmul(mat_a, mat_b));
        accepts++;
        mat_a = rand_mat(); mat_b = rand_mat();
        if (accepts == 3) in_valid0 = 1'b0;
      end
    end
    vectors++; if (dones !== 3) begin miscompares++; $display("FAIL b2b_jobs_done got %0d expected 3", dones); end
    in_valid0 = 1'b0; out_ready0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fill();
    test_hold();
    test_reset_mid();
    test_lat3();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
